ddr4_v2_2_24_tg_victim_sweep_ctrl: RTL
======================================

// Module: ddr4_v2_2_24_tg_victim_sweep_ctrl
// PURPOSE
//  Sequences the TG victim data-pattern generator through a programmed sweep of (victim_mode, victim_bit, aggr_delay).
//  Drives the generator's config, victim_en and victim_hold; flushes its pipeline on every config change.
//  Issues a fixed number of accepted beats per step, then advances. Sits between TG control FSM and generator.
// PARAMETERS
//  TCQ             100  clock-to-q delay (ps) on all registered outputs
//  NUM_DQ_PINS     72   DQ width; bounds victim_bit and sizes victim_mask
//  GEN_PIPE_LAT    4    generator enabled-cycle latency (victim_in -> victim_valid)
//  MAX_AGGR_DELAY  24   largest legal aggr delay ((4-1)*2*nCK_PER_CLK)
// PORTS
//  clk                input   1     clock
//  rst                input   1     synchronous active-high reset
//  start              input   1     pulse: latch cfg_*, begin sweep (ignored while busy)
//  abort              input   1     pulse: stop sweep, return to IDLE
//  cfg_mode_mask      input   8     bit m=1 -> run victim mode m (0..7)
//  cfg_bit_lo/hi      input   8/8   victim bit range, inclusive
//  cfg_dly_max        input   5     delay sweep 0..cfg_dly_max (modes 5,6 only)
//  cfg_beats          input   16    accepted beats per step; 0 treated as 1
//  beat_ready         input   1     consumer ready; ~beat_ready stalls generator in RUN
//  victim_mode        output  3     to generator
//  victim_bit         output  8     to generator
//  victim_mask        output  NUM_DQ_PINS  one-hot of victim_bit (bit0 in mode 7)
//  victim_aggr_delay  output  5     to generator
//  victim_en          output  1     generator enable
//  victim_hold        output  1     generator stall
//  step_active        output  1     generator output belongs to current step (RUN)
//  step_idx           output  16    steps completed in this sweep
//  busy               output  1     sweep in progress
//  done               output  1     1-cycle pulse at normal sweep end
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0; rst overrides start/abort.
//  FSM: IDLE -> LOAD -> FLUSH -> RUN -> NEXT -> (LOAD | DONE) -> IDLE.
//  IDLE: en=0, hold=0, busy=0. start latches cfg_*; clamp bit_hi/lo to NUM_DQ_PINS-1,
//   dly_max to MAX_AGGR_DELAY; lo>hi -> single bit lo. mode_mask==0 -> DONE directly.
//   Else first tuple = lowest set mode, bit_lo, delay 0; step_idx<=0.
//  LOAD (1 cycle): config outputs take new tuple; en=0.
//  FLUSH: en=1, hold=0; count GEN_PIPE_LAT cycles, step_active=0; then RUN.
//  RUN: en=1, hold=~beat_ready, step_active=1; beat counts when en&&!hold;
//   last accepted beat (cfg_beats-1) -> NEXT.
//  NEXT (1 cycle): en=0; step_idx+=1 (saturates 16'hFFFF).
//   Order: delay innermost, then bit, then mode.
//   Delay iterates only for modes 5,6, else fixed 0; bit fixed 0 for modes 0 and 7.
//   Unselected modes skipped; past last tuple -> DONE.
//  DONE: done=1 one cycle, busy=0 next cycle, -> IDLE; config outputs hold last tuple.
//  abort in any non-IDLE state: next cycle IDLE, en=0, hold=0, step_active=0, no done.
//  start and abort same cycle in IDLE: abort wins (stay IDLE).
//  beat_ready low in FLUSH ignored; flush never stalls.
//  Config outputs change only in LOAD; stable for whole FLUSH+RUN.
// STRUCTURE
//  Package ddr4_v2_2_24_tg_victim_pkg: victim mode localparams (NO_VICTIM..CAL_CPLX),
//   sweep state enum, mode predicates (uses_bit, uses_delay); shared with generator.
//  Sub-module ddr4_v2_2_24_tg_victim_step_iter: holds (mode,bit,dly), computes next tuple
//   and last flag from latched cfg; advance strobe from FSM.
// TESTING
//  mask=8'h02, bits 3..5, beats=4, ready=1 -> 3 steps bit 3,4,5; each LOAD+4 FLUSH+4 RUN; done, step_idx=3.
//  mask=8'h20, bit 7..7, dly_max=2 -> delays 0,1,2 at bit 7; dly_max=31 clamps to 24 (25 steps).
//  mask=8'h81, beats=0 -> 2 steps (mode0 bit0, mode7 mask=1); beats treated as 1; done after 2nd.
//  RUN beats=8, ready toggling 1010.. -> hold=~ready; exactly 8 accepted beats; config stable.
//  abort mid-FLUSH of step 2 -> next cycle en=0, busy=0, no done; new start runs from step 0.
//  mask=0 start -> done 2nd cycle, en never high; start while busy -> ignored, cfg unchanged.

Source files
------------

// File: rtl/ddr4_v2_2_24_tg_victim_pkg.sv
// Victim-mode encodings, sweep FSM states and mode predicates, shared by the sweep controller and the generator.
package ddr4_v2_2_24_tg_victim_pkg;

  localparam logic [2:0] NO_VICTIM    = 3'd0;
  localparam logic [2:0] HELD1        = 3'd1;
  localparam logic [2:0] HELD0        = 3'd2;
  localparam logic [2:0] NONINV_CYCLE = 3'd3;
  localparam logic [2:0] INV_CYCLE    = 3'd4;
  localparam logic [2:0] DLY_NONINV   = 3'd5;
  localparam logic [2:0] DLY_INV      = 3'd6;
  localparam logic [2:0] CAL_CPLX     = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_NEXT,
    S_DONE
  } sweep_state_t;

  function automatic logic uses_bit(input logic [2:0] mode);
    logic r;
    case (mode)
      HELD1, HELD0, NONINV_CYCLE, INV_CYCLE, DLY_NONINV, DLY_INV: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic uses_delay(input logic [2:0] mode);
    return (mode == DLY_NONINV) || (mode == DLY_INV);
  endfunction

endpackage

// File: rtl/ddr4_v2_2_24_tg_victim_step_iter.sv
// Holds the current (mode, bit, delay) sweep tuple and its one-hot mask; latches clamped config on init,
// steps delay-innermost / bit / mode on advance, and flags the final tuple.
module ddr4_v2_2_24_tg_victim_step_iter
  import ddr4_v2_2_24_tg_victim_pkg::*;
#(
  parameter int NUM_DQ_PINS    = 72,
  parameter int MAX_AGGR_DELAY = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init,
  input  logic                   advance,
  input  logic [7:0]             cfg_mode_mask,
  input  logic [7:0]             cfg_bit_lo,
  input  logic [7:0]             cfg_bit_hi,
  input  logic [4:0]             cfg_dly_max,
  output logic [2:0]             mode,
  output logic [7:0]             bit_idx,
  output logic [4:0]             dly,
  output logic [NUM_DQ_PINS-1:0] mask,
  output logic                   last
);

  localparam logic [7:0]             BIT_MAX = 8'(NUM_DQ_PINS - 1);
  localparam logic [4:0]             DLY_CAP = 5'(MAX_AGGR_DELAY);
  localparam logic [NUM_DQ_PINS-1:0] ONE     = NUM_DQ_PINS'(1);

  logic [7:0] mode_mask_q, bit_lo_q, bit_hi_q;
  logic [4:0] dly_max_q;
  logic [7:0] lo_c, hi_c;
  logic [4:0] dmax_c;
  logic [2:0] first_mode, up_mode, nxt_mode;
  logic       up_found;
  logic [7:0] nxt_bit, first_bit;
  logic [4:0] nxt_dly;

  // Clamp the incoming range; an inverted range collapses to the single bit lo.
  always_comb begin
    lo_c   = (cfg_bit_lo > BIT_MAX) ? BIT_MAX : cfg_bit_lo;
    hi_c   = (cfg_bit_hi > BIT_MAX) ? BIT_MAX : cfg_bit_hi;
    if (lo_c > hi_c) hi_c = lo_c;
    dmax_c = (cfg_dly_max > DLY_CAP) ? DLY_CAP : cfg_dly_max;
    first_mode = 3'd0;
    for (int m = 7; m >= 0; m--) begin
      if (cfg_mode_mask[m]) first_mode = 3'(m);
    end
    first_bit = uses_bit(first_mode) ? lo_c : 8'd0;
  end

  always_comb begin
    up_found = 1'b0;
    up_mode  = mode;
    for (int m = 7; m >= 0; m--) begin
      if (m > int'(mode) && mode_mask_q[m]) begin
        up_found = 1'b1;
        up_mode  = 3'(m);
      end
    end
    nxt_mode = mode;
    nxt_bit  = bit_idx;
    nxt_dly  = dly;
    last     = 1'b0;
    if (uses_delay(mode) && dly < dly_max_q) begin
      nxt_dly = dly + 5'd1;
    end else if (uses_bit(mode) && bit_idx < bit_hi_q) begin
      nxt_bit = bit_idx + 8'd1;
      nxt_dly = 5'd0;
    end else if (up_found) begin
      nxt_mode = up_mode;
      nxt_bit  = uses_bit(up_mode) ? bit_lo_q : 8'd0;
      nxt_dly  = 5'd0;
    end else begin
      last = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_mask_q <= '0;
      bit_lo_q    <= '0;
      bit_hi_q    <= '0;
      dly_max_q   <= '0;
      mode        <= '0;
      bit_idx     <= '0;
      dly         <= '0;
      mask        <= '0;
    end else if (init) begin
      mode_mask_q <= cfg_mode_mask;
      bit_lo_q    <= lo_c;
      bit_hi_q    <= hi_c;
      dly_max_q   <= dmax_c;
      mode        <= first_mode;
      bit_idx     <= first_bit;
      dly         <= 5'd0;
      mask        <= ONE << first_bit;
    end else if (advance) begin
      mode    <= nxt_mode;
      bit_idx <= nxt_bit;
      dly     <= nxt_dly;
      mask    <= ONE << nxt_bit;
    end
  end

endmodule

// File: rtl/ddr4_v2_2_24_tg_victim_sweep_ctrl.sv
// Sweeps the victim pattern generator through (mode, bit, delay) steps: load config, flush the generator
// pipeline, run a fixed count of accepted beats, advance; abort returns to idle without a done pulse.
module ddr4_v2_2_24_tg_victim_sweep_ctrl
  import ddr4_v2_2_24_tg_victim_pkg::*;
#(
  parameter int TCQ            = 100,
  parameter int NUM_DQ_PINS    = 72,
  parameter int GEN_PIPE_LAT   = 4,
  parameter int MAX_AGGR_DELAY = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [7:0]             cfg_mode_mask,
  input  logic [7:0]             cfg_bit_lo,
  input  logic [7:0]             cfg_bit_hi,
  input  logic [4:0]             cfg_dly_max,
  input  logic [15:0]            cfg_beats,
  input  logic                   beat_ready,
  output logic [2:0]             victim_mode,
  output logic [7:0]             victim_bit,
  output logic [NUM_DQ_PINS-1:0] victim_mask,
  output logic [4:0]             victim_aggr_delay,
  output logic                   victim_en,
  output logic                   victim_hold,
  output logic                   step_active,
  output logic [15:0]            step_idx,
  output logic                   busy,
  output logic                   done
);

  // TCQ only matters to behavioural models of the generator; the registers here carry no modelled delay.
  if (TCQ < 0 || GEN_PIPE_LAT < 1 || MAX_AGGR_DELAY > 31 || NUM_DQ_PINS < 1 || NUM_DQ_PINS > 256)
  begin : g_bad_param
    $error("ddr4_v2_2_24_tg_victim_sweep_ctrl: illegal parameter set");
  end

  localparam logic [15:0] FLUSH_LAST = 16'(GEN_PIPE_LAT - 1);

  sweep_state_t state, nxt_state;
  logic [15:0]  beats_m1, beat_cnt, flush_cnt;
  logic         iter_init, iter_adv, iter_last, accept_start;

  assign accept_start = (state == S_IDLE) && start && !abort;

  always_comb begin
    nxt_state   = state;
    iter_init   = 1'b0;
    iter_adv    = 1'b0;
    victim_en   = 1'b0;
    victim_hold = 1'b0;
    step_active = 1'b0;
    done        = 1'b0;
    busy        = (state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        if (accept_start) begin
          iter_init = (cfg_mode_mask != 8'd0);
          nxt_state = iter_init ? S_LOAD : S_DONE;
        end
      end
      S_LOAD:  nxt_state = S_FLUSH;
      S_FLUSH: begin
        victim_en = 1'b1;
        if (flush_cnt == FLUSH_LAST) nxt_state = S_RUN;
      end
      S_RUN: begin
        victim_en   = 1'b1;
        victim_hold = ~beat_ready;
        step_active = 1'b1;
        if (beat_ready && beat_cnt == beats_m1) nxt_state = S_NEXT;
      end
      S_NEXT: begin
        iter_adv  = !iter_last;
        nxt_state = iter_last ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done      = 1'b1;
        nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      nxt_state = S_IDLE;
      iter_adv  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      beats_m1  <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      step_idx  <= '0;
    end else begin
      state <= nxt_state;
      if (accept_start) begin
        beats_m1 <= (cfg_beats == 16'd0) ? 16'd0 : cfg_beats - 16'd1;
        step_idx <= '0;
      end
      flush_cnt <= (state == S_FLUSH) ? flush_cnt + 16'd1 : 16'd0;
      beat_cnt  <= (state == S_RUN) ? beat_cnt + 16'(beat_ready) : 16'd0;
      if (state == S_NEXT && !abort && step_idx != 16'hFFFF) step_idx <= step_idx + 16'd1;
    end
  end

  ddr4_v2_2_24_tg_victim_step_iter #(
    .NUM_DQ_PINS   (NUM_DQ_PINS),
    .MAX_AGGR_DELAY(MAX_AGGR_DELAY)
  ) u_iter (
    .clk          (clk),
    .rst          (rst),
    .init         (iter_init),
    .advance      (iter_adv),
    .cfg_mode_mask(cfg_mode_mask),
    .cfg_bit_lo   (cfg_bit_lo),
    .cfg_bit_hi   (cfg_bit_hi),
    .cfg_dly_max  (cfg_dly_max),
    .mode         (victim_mode),
    .bit_idx      (victim_bit),
    .dly          (victim_aggr_delay),
    .mask         (victim_mask),
    .last         (iter_last)
  );

endmodule
